// File: rtl/popcount_accum_if.sv
// Handshake bundle for popcount_accum: beat input channel and frame-result
// output channel.
interface popcount_accum_if #(
  parameter int CNT_W  = 8,
  parameter int BEAT_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_bits;
  logic              in_cin;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic [BEAT_W-1:0] out_beats;
  logic              out_ovf;

  modport master (
    output in_valid, in_bits, in_cin, in_last, out_ready,
    input  in_ready, out_valid, out_count, out_beats, out_ovf
  );

  modport slave (
    input  in_valid, in_bits, in_cin, in_last, out_ready,
    output in_ready, out_valid, out_count, out_beats, out_ovf
  );
endinterface

// File: rtl/popcount_accum.sv
// Frame popcount accumulator: sums set bits of {in_bits,in_cin} over a frame,
// counts beats, and presents saturating totals until downstream takes them.
module popcount_accum #(
  parameter int CNT_W  = 8,
  parameter int BEAT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  popcount_accum_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_acc;
  logic [BEAT_W-1:0] r_beats;

  logic              w_accept;
  logic [CNT_W:0]    w_weight;
  logic [CNT_W:0]    w_sum;
  logic              w_acc_clip;
  logic              w_beat_clip;
  logic [CNT_W-1:0]  w_acc_next;
  logic [BEAT_W-1:0] w_beats_next;

  // Five-input bit count as the 3-bit value {c1,c0,s}.
  function automatic logic [2:0] weight5(input logic [3:0] b, input logic c);
    weight5 = {2'b00, b[0]} + {2'b00, b[1]} + {2'b00, b[2]} + {2'b00, b[3]} + {2'b00, c};
  endfunction

  // Saturating next values for the accumulator and beat counter.
  always_comb begin
    w_accept     = bus.in_valid & r_in_ready;
    w_weight     = {{(CNT_W-2){1'b0}}, weight5(bus.in_bits, bus.in_cin)};
    w_sum        = {1'b0, r_acc} + w_weight;
    w_acc_clip   = w_sum[CNT_W];
    w_beat_clip  = &r_beats;
    if (w_acc_clip) begin
      w_acc_next = {CNT_W{1'b1}};
    end else begin
      w_acc_next = w_sum[CNT_W-1:0];
    end
    if (w_beat_clip) begin
      w_beats_next = r_beats;
    end else begin
      w_beats_next = r_beats + {{(BEAT_W-1){1'b0}}, 1'b1};
    end
  end

  // Frame FSM; ready is registered so it stays low through reset and in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_acc       <= {CNT_W{1'b0}};
      r_beats     <= {BEAT_W{1'b0}};
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_acc   <= w_acc_next;
            r_beats <= w_beats_next;
            r_ovf   <= r_ovf | w_acc_clip | w_beat_clip;
            if (bus.in_last) begin
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_acc       <= {CNT_W{1'b0}};
            r_beats     <= {BEAT_W{1'b0}};
          end else begin
            r_state <= HOLD;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_ovf       <= 1'b0;
          r_acc       <= {CNT_W{1'b0}};
          r_beats     <= {BEAT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_count = r_acc;
  assign bus.out_beats = r_beats;
  assign bus.out_ovf   = r_ovf;

endmodule

// File: tb/tb_popcount_accum.sv
// Directed bench for popcount_accum: default-width instance plus a 4-bit
// instance for saturation cases.
module tb_popcount_accum;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  popcount_accum_if #(.CNT_W(8), .BEAT_W(8)) ifc  ();
  popcount_accum_if #(.CNT_W(4), .BEAT_W(4)) ifc4 ();

  popcount_accum #(.CNT_W(8), .BEAT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  popcount_accum #(.CNT_W(4), .BEAT_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic v, input logic [3:0] b, input logic c, input logic l);
    if (sel) begin
      ifc4.in_valid = v; ifc4.in_bits = b; ifc4.in_cin = c; ifc4.in_last = l;
    end else begin
      ifc.in_valid = v; ifc.in_bits = b; ifc.in_cin = c; ifc.in_last = l;
    end
  endtask

  // Present one beat and hold it until the edge that accepts it; returns at posedge+1.
  task automatic send(input logic sel, input logic [3:0] b, input logic c, input logic l);
    int n;
    n = 0;
    drive(sel, 1'b1, b, c, l);
    @(negedge clk);
    while (((sel ? ifc4.in_ready : ifc.in_ready) !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rb;
    logic       rc;
    int         exp_cnt;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    ifc.out_ready  = 1'b1;
    ifc4.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_in_ready",  32'(ifc.in_ready),  32'd0);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_out_count", 32'(ifc.out_count), 32'd0);
    chk("rst_out_beats", 32'(ifc.out_beats), 32'd0);
    chk("rst_out_ovf",   32'(ifc.out_ovf),   32'd0);
    #5 rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(ifc.in_ready), 32'd1);

    // Three-beat frame: 5 + 0 + 3
    send(1'b0, 4'b1111, 1'b1, 1'b0);
    send(1'b0, 4'b0000, 1'b0, 1'b0);
    send(1'b0, 4'b1010, 1'b1, 1'b1);
    chk("f1_valid", 32'(ifc.out_valid), 32'd1);
    chk("f1_count", 32'(ifc.out_count), 32'd8);
    chk("f1_beats", 32'(ifc.out_beats), 32'd3);
    chk("f1_ovf",   32'(ifc.out_ovf),   32'd0);
    chk("f1_ready", 32'(ifc.in_ready),  32'd0);
    step();
    chk("f1_valid_drop", 32'(ifc.out_valid), 32'd0);
    chk("f1_ready_back", 32'(ifc.in_ready),  32'd1);

    // Single-beat frame held while downstream stalls; HOLD ignores beats
    ifc.out_ready = 1'b0;
    send(1'b0, 4'b0110, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
      chk("hold_valid", 32'(ifc.out_valid), 32'd1);
      chk("hold_count", 32'(ifc.out_count), 32'd2);
      chk("hold_beats", 32'(ifc.out_beats), 32'd1);
      chk("hold_ready", 32'(ifc.in_ready),  32'd0);
      step();
    end
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("hold_end_count", 32'(ifc.out_count), 32'd2);
    ifc.out_ready = 1'b1;
    step();
    chk("hold_release", 32'(ifc.out_valid), 32'd0);

    // Ten beats with random idle gaps carrying junk data
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      while ($urandom_range(1, 0) == 1) begin
        rb = 4'($urandom);
        rc = 1'($urandom);
        drive(1'b0, 1'b0, rb, rc, 1'b1);
        step();
      end
      rb = 4'($urandom);
      rc = 1'($urandom);
      exp_cnt += $countones({rb, rc});
      send(1'b0, rb, rc, (i == 9) ? 1'b1 : 1'b0);
    end
    chk("rand_valid", 32'(ifc.out_valid), 32'd1);
    chk("rand_count", 32'(ifc.out_count), 32'(exp_cnt));
    chk("rand_beats", 32'(ifc.out_beats), 32'd10);
    step();

    // Reset in the middle of a frame discards it
    send(1'b0, 4'b1111, 1'b1, 1'b0);
    send(1'b0, 4'b1111, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(ifc.out_count), 32'd0);
    chk("mid_rst_beats", 32'(ifc.out_beats), 32'd0);
    chk("mid_rst_ready", 32'(ifc.in_ready),  32'd0);
    #10 rst_n = 1'b1;
    step();
    chk("mid_rst_novalid", 32'(ifc.out_valid), 32'd0);
    send(1'b0, 4'b0001, 1'b0, 1'b1);
    chk("after_rst_valid", 32'(ifc.out_valid), 32'd1);
    chk("after_rst_count", 32'(ifc.out_count), 32'd1);
    chk("after_rst_beats", 32'(ifc.out_beats), 32'd1);
    step();

    // Back-to-back frames: one bubble cycle between them
    send(1'b0, 4'b0011, 1'b0, 1'b0);
    send(1'b0, 4'b0111, 1'b1, 1'b1);
    chk("b2b_a_count",  32'(ifc.out_count), 32'd6);
    chk("b2b_a_beats",  32'(ifc.out_beats), 32'd2);
    chk("b2b_bubble",   32'(ifc.in_ready),  32'd0);
    step();
    chk("b2b_ready",    32'(ifc.in_ready),  32'd1);
    send(1'b0, 4'b1000, 1'b1, 1'b0);
    send(1'b0, 4'b1101, 1'b0, 1'b1);
    chk("b2b_b_valid",  32'(ifc.out_valid), 32'd1);
    chk("b2b_b_count",  32'(ifc.out_count), 32'd5);
    chk("b2b_b_beats",  32'(ifc.out_beats), 32'd2);
    step();

    // Narrow instance: beat counter saturates after 15 beats
    for (int i = 0; i < 17; i++) begin
      send(1'b1, 4'b0000, 1'b0, (i == 16) ? 1'b1 : 1'b0);
    end
    chk("bsat_beats", 32'(ifc4.out_beats), 32'd15);
    chk("bsat_count", 32'(ifc4.out_count), 32'd0);
    chk("bsat_ovf",   32'(ifc4.out_ovf),   32'd1);
    step();

    // Narrow instance: accumulator saturates at 15
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 4'b1111, 1'b1, (i == 3) ? 1'b1 : 1'b0);
    end
    chk("csat_count", 32'(ifc4.out_count), 32'd15);
    chk("csat_beats", 32'(ifc4.out_beats), 32'd4);
    chk("csat_ovf",   32'(ifc4.out_ovf),   32'd1);
    step();
    send(1'b1, 4'b0001, 1'b1, 1'b1);
    chk("next_count", 32'(ifc4.out_count), 32'd2);
    chk("next_ovf",   32'(ifc4.out_ovf),   32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
